// File: rtl/inst_rom_resp.sv
// Loadable instruction memory behind a valid/ready fetch port with registered responses.
// Define INST_ROM_WAIT_EN to insert WAIT_CYCLES of extra response latency (WAIT state).
module inst_rom_resp #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH_LOG2  = 12,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] NOP_INST    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req_valid_i,
  output logic        inst_req_ready_o,
  input  logic [31:0] inst_addr_i,
  output logic        inst_resp_valid_o,
  input  logic        inst_resp_ready_i,
  output logic [31:0] inst_o,
  output logic        inst_err_o,
  input  logic        wr_en_i,
  input  logic [31:0] wr_addr_i,
  input  logic [31:0] wr_data_i
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("WAIT_CYCLES must be in 1..15");
  end
  if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 29) begin : g_bad_depth
    $error("DEPTH_LOG2 must be in 1..29");
  end

  // Out of range when any offset bit above the word index is set.
  function automatic logic addr_bad(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return (addr[1:0] != 2'b00) || (addr < BASE_ADDR) || ((off >> (DEPTH_LOG2 + 2)) != 32'd0);
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] addr_idx(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return off[DEPTH_LOG2+1:2];
  endfunction

`ifdef INST_ROM_WAIT_EN
  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;
`else
  typedef enum logic {StIdle, StResp} state_e;
`endif

  state_e      state_q, state_d;
  logic        accept;
  logic        resp_load;
  logic [31:0] rd_addr;
  logic        rd_bad;
  logic [31:0] rd_word;
  logic [31:0] inst_q;
  logic        err_q;
  logic [31:0] mem [Depth];

`ifdef INST_ROM_WAIT_EN
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= 4'd0;
      addr_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
      if (accept) begin
        addr_q <= inst_addr_i;
      end
    end
  end
`endif

  always_comb begin
    state_d          = state_q;
    inst_req_ready_o = 1'b0;
    resp_load        = 1'b0;
    rd_addr          = inst_addr_i;
`ifdef INST_ROM_WAIT_EN
    cnt_d            = cnt_q;
`endif

    case (state_q)
      StIdle:  inst_req_ready_o = 1'b1;
      StResp:  inst_req_ready_o = inst_resp_ready_i;
      default: inst_req_ready_o = 1'b0;
    endcase
    if (rst) begin
      inst_req_ready_o = 1'b0;
    end
    accept = inst_req_valid_i & inst_req_ready_o;

    case (state_q)
      StResp: begin
        if (inst_resp_ready_i) begin
          state_d = StIdle;
        end
      end
`ifdef INST_ROM_WAIT_EN
      StWait: begin
        if (cnt_q == 4'(WAIT_CYCLES - 1)) begin
          state_d   = StResp;
          cnt_d     = 4'd0;
          resp_load = 1'b1;
          rd_addr   = addr_q;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
`endif
      default: ;
    endcase

    // An accept in RESP overrides the return to IDLE (back-to-back).
    if (accept) begin
`ifdef INST_ROM_WAIT_EN
      state_d = StWait;
      cnt_d   = 4'd0;
`else
      state_d   = StResp;
      resp_load = 1'b1;
`endif
    end
  end

  assign rd_bad  = addr_bad(rd_addr);
  assign rd_word = mem[addr_idx(rd_addr)];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      inst_q  <= NOP_INST;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (resp_load) begin
        inst_q <= rd_bad ? NOP_INST : rd_word;
        err_q  <= rd_bad;
      end
    end
  end

  // Not reset; a same-edge load returns the old word to the reader.
  always_ff @(posedge clk) begin
    if (wr_en_i && !addr_bad(wr_addr_i)) begin
      mem[addr_idx(wr_addr_i)] <= wr_data_i;
    end
  end

  assign inst_resp_valid_o = (state_q == StResp);
  assign inst_o            = inst_q;
  assign inst_err_o        = err_q;

endmodule

// File: doc/inst_rom_resp.md
INST_ROM_RESP -- requirements
Module: inst_rom_resp

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h8000_0000, meaning the byte address of memory word 0.
REQ-002 The block SHALL have parameter DEPTH_LOG2, default 12, meaning log2 of the number of 32-bit words stored (4096).
REQ-003 The block SHALL have parameter WAIT_CYCLES, default 2, meaning the added response delay in cycles; it is used only when INST_ROM_WAIT_EN is defined; legal range is 1..15.
REQ-004 The block SHALL have parameter NOP_INST, default 32'h0000_0013, meaning the instruction word returned at reset and on error.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port inst_req_valid_i, input, 1 bit: the core presents a fetch request.
REQ-008 The block SHALL have port inst_req_ready_o, output, 1 bit: the block accepts a request this cycle.
REQ-009 The block SHALL have port inst_addr_i, input, 32 bits: the fetch byte address.
REQ-010 The block SHALL have port inst_resp_valid_o, output, 1 bit: the response is valid.
REQ-011 The block SHALL have port inst_resp_ready_i, input, 1 bit: the core takes the response.
REQ-012 The block SHALL have port inst_o, output, 32 bits: the fetched instruction.
REQ-013 The block SHALL have port inst_err_o, output, 1 bit: the fetch faulted; the flag is qualified by inst_resp_valid_o.
REQ-014 The block SHALL have load port inputs wr_en_i (1 bit), wr_addr_i (32 bits, byte address) and wr_data_i (32 bits).

Function
REQ-015 The block SHALL implement the FSM states IDLE, WAIT and RESP.
REQ-016 inst_req_ready_o SHALL be 1 in IDLE, and 1 in RESP only when inst_resp_ready_i=1; it SHALL be 0 in WAIT.
REQ-017 A request SHALL be accepted when inst_req_valid_i and inst_req_ready_o are both 1; inst_addr_i SHALL be captured on that edge.
REQ-018 On accept, the next state SHALL be RESP when INST_ROM_WAIT_EN is undefined, and WAIT when it is defined.
REQ-019 In WAIT, a 4-bit counter SHALL count up from 0; the FSM SHALL move to RESP on the edge where the counter equals WAIT_CYCLES-1.
REQ-020 inst_resp_valid_o SHALL equal 1 exactly while the FSM is in RESP.
REQ-021 inst_o and inst_err_o SHALL be registered and SHALL stay stable while inst_resp_valid_o=1 and inst_resp_ready_i=0.
REQ-022 In RESP, a response handshake with no new request SHALL move the FSM to IDLE.
REQ-023 In RESP, a response handshake together with a new request SHALL accept the new request in the same cycle (back-to-back); the FSM SHALL stay in RESP or move to WAIT according to REQ-018.
REQ-024 Word index SHALL be (addr - BASE_ADDR) >> 2, using 32-bit unsigned arithmetic.
REQ-025 A fetch SHALL be an error when any of these holds: addr[1:0] != 0; addr < BASE_ADDR; index >= 2^DEPTH_LOG2.
REQ-026 On an error, the response SHALL be inst_err_o=1 and inst_o=NOP_INST.
REQ-027 On a non-error fetch, the response SHALL be inst_err_o=0 and inst_o=mem[index].
REQ-028 The response data SHALL be sampled from memory on the edge that enters RESP.
REQ-029 A load write to the same word on the sampling edge (REQ-028) SHALL return the old contents (read-before-write).
REQ-030 When wr_en_i=1, the block SHALL write wr_data_i to mem[index of wr_addr_i] on the edge, in any FSM state.
REQ-031 A load write whose address meets the error rule (REQ-025) SHALL be dropped silently.

Reset
REQ-032 When rst=1, the block SHALL immediately force: state=IDLE, wait counter=0, inst_resp_valid_o=0, inst_err_o=0, inst_o=NOP_INST.
REQ-033 During reset, inst_req_ready_o SHALL be 0.
REQ-034 Reset asserted mid-request (in WAIT or RESP) SHALL discard the pending response; no response SHALL be produced for it after release.
REQ-035 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-036 The macro INST_ROM_WAIT_EN SHALL control the response delay.
REQ-037 When INST_ROM_WAIT_EN is undefined, response latency SHALL be 1 cycle (valid on the cycle after accept), and the WAIT state and counter SHALL not be built.
REQ-038 When INST_ROM_WAIT_EN is defined, response latency SHALL be 1+WAIT_CYCLES cycles.

Verification
REQ-039 Load mem[0]=32'h0010_0093, then request addr 32'h8000_0000 with resp_ready=1 -> valid one cycle later, inst_o=32'h0010_0093, err=0.
REQ-040 Request addr 32'h8000_0002 -> err=1, inst_o=32'h0000_0013.
REQ-041 Request addr 32'h7FFF_FFFC -> err=1, inst_o=32'h0000_0013.
REQ-042 Request addr 32'h8000_4000 -> err=1, inst_o=32'h0000_0013.
REQ-043 Hold resp_ready=0 for 5 cycles -> valid and inst_o stable; then resp_ready=1 with a new request for addr 32'h8000_0004 -> back-to-back accept, next response is mem[1].
REQ-044 With INST_ROM_WAIT_EN defined and WAIT_CYCLES=3 -> valid exactly 4 cycles after accept; ready=0 during WAIT.
REQ-045 Assert rst while in RESP -> valid=0 at once, inst_o=32'h0000_0013; after release no stale response appears.
